// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - byte handshake between a requester and the UART transmit sequencer
interface uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit sequencer: start, 8 data bits LSB first, optional even parity, stop
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b1,
    parameter int STOP_BITS    = 1
) (
    input  logic      clk,
    input  logic      rst,
    uart_tx_if.slave  bus,
    output logic      par_load,
    output logic      tx,
    output logic      busy,
    output logic      done
);
    localparam int STOP_LEN = STOP_BITS * CLKS_PER_BIT;
    localparam int CW       = $clog2(STOP_LEN);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_LEN - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shift, shift_n;
    logic          parity_bit, parity_n;
    logic          tx_n, busy_n, done_n, ready_n, par_load_n;
    logic          accept;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt + 1'b1;
        bit_n      = bit_idx;
        shift_n    = shift;
        parity_n   = parity_bit;
        par_load_n = 1'b0;
        accept     = bus.tx_valid && bus.tx_ready;

        case (state)
            IDLE: begin
                cnt_n = '0;
                if (accept) begin
                    state_n    = START;
                    shift_n    = bus.tx_data;
                    parity_n   = ^bus.tx_data;
                    par_load_n = 1'b1;
                end
            end
            START: begin
                if (cnt == BIT_LAST) begin
                    state_n = DATA;
                    cnt_n   = '0;
                    bit_n   = '0;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    shift_n = {1'b0, shift[7:1]};
                    bit_n   = bit_idx + 1'b1;
                    if (bit_idx == 3'd7)
                        state_n = PARITY_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (cnt == BIT_LAST) begin
                    state_n = STOP;
                    cnt_n   = '0;
                end
            end
            STOP: begin
                if (cnt == STOP_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        // Outputs are decoded from the next state so the registered copies line up with it
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            PARITY:  tx_n = parity_n;
            default: tx_n = 1'b1;
        endcase
        busy_n  = (state_n != IDLE);
        ready_n = (state_n == IDLE);
        done_n  = (state_n == STOP) && (cnt_n == STOP_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            parity_bit   <= 1'b0;
            tx           <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            bus.tx_ready <= 1'b1;
            par_load     <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            bit_idx      <= bit_n;
            shift        <= shift_n;
            parity_bit   <= parity_n;
            tx           <= tx_n;
            busy         <= busy_n;
            done         <= done_n;
            bus.tx_ready <= ready_n;
            par_load     <= par_load_n;
        end
    end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - scoreboard bench for uart_tx_ctrl (parity/1 stop and no parity/2 stop instances)
module tb_uart_tx_ctrl;
    localparam int FRAME = 176;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_if bus_a ();
    uart_tx_if bus_b ();

    logic par_a, tx_a, busy_a, done_a;
    logic par_b, tx_b, busy_b, done_b;

    uart_tx_ctrl #(.CLKS_PER_BIT(16), .PARITY_EN(1'b1), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a),
        .par_load(par_a), .tx(tx_a), .busy(busy_a), .done(done_a));

    uart_tx_ctrl #(.CLKS_PER_BIT(16), .PARITY_EN(1'b0), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b),
        .par_load(par_b), .tx(tx_b), .busy(busy_b), .done(done_b));

    logic m_tx[2], m_busy[2], m_done[2], m_par[2], m_ready[2];
    assign m_tx[0] = tx_a;   assign m_busy[0] = busy_a; assign m_done[0] = done_a;
    assign m_par[0] = par_a; assign m_ready[0] = bus_a.tx_ready;
    assign m_tx[1] = tx_b;   assign m_busy[1] = busy_b; assign m_done[1] = done_b;
    assign m_par[1] = par_b; assign m_ready[1] = bus_b.tx_ready;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected frames, first transmitted bit in the MSB
    logic [10:0] q_a[$];
    logic [10:0] q_b[$];

    task automatic check_bit(input string name, input logic act, input logic req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0b, required %0b", name, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic monitor(input int d);
        logic [10:0] e;
        bit have;
        bit aborted;
        int done_at, done_cnt, bad_busy, bad_ready, bad_par, fn;
        fn = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (m_done[d]) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL dut%0d stray_done: done=1 outside a frame, required 0", d);
                end
                if (m_par[d]) begin
                    have = (d == 0) ? (q_a.size() > 0) : (q_b.size() > 0);
                    check_bit($sformatf("dut%0d frame%0d expected_present", d, fn), have, 1'b1);
                    e = 11'h7ff;
                    if (have) e = (d == 0) ? q_a.pop_front() : q_b.pop_front();
                    aborted = 0;
                    done_at = 0; done_cnt = 0; bad_busy = 0; bad_ready = 0; bad_par = 0;
                    for (int c = 1; c <= FRAME + 1; c++) begin
                        if (c > 1) @(negedge clk);
                        if (rst) begin
                            check_bit($sformatf("dut%0d abort tx", d), m_tx[d], 1'b1);
                            check_bit($sformatf("dut%0d abort busy", d), m_busy[d], 1'b0);
                            check_bit($sformatf("dut%0d abort ready", d), m_ready[d], 1'b1);
                            check_bit($sformatf("dut%0d abort done", d), m_done[d], 1'b0);
                            aborted = 1;
                            break;
                        end
                        if (c <= FRAME) begin
                            if (!m_busy[d]) bad_busy++;
                            if (m_ready[d]) bad_ready++;
                            if (c > 1 && m_par[d]) bad_par++;
                            if (m_done[d]) begin
                                done_cnt++;
                                if (done_at == 0) done_at = c;
                            end
                            if (c >= 8 && ((c - 8) % 16) == 0)
                                check_bit($sformatf("dut%0d frame%0d bit%0d", d, fn, (c - 8) / 16),
                                          m_tx[d], e[10 - (c - 8) / 16]);
                        end else begin
                            check_bit($sformatf("dut%0d frame%0d post ready", d, fn), m_ready[d], 1'b1);
                            check_bit($sformatf("dut%0d frame%0d post busy", d, fn), m_busy[d], 1'b0);
                            check_bit($sformatf("dut%0d frame%0d post tx", d, fn), m_tx[d], 1'b1);
                        end
                    end
                    if (!aborted) begin
                        check_int($sformatf("dut%0d frame%0d done_cycle", d, fn), done_at, FRAME);
                        check_int($sformatf("dut%0d frame%0d done_count", d, fn), done_cnt, 1);
                        check_int($sformatf("dut%0d frame%0d busy_low_cycles", d, fn), bad_busy, 0);
                        check_int($sformatf("dut%0d frame%0d ready_high_cycles", d, fn), bad_ready, 0);
                        check_int($sformatf("dut%0d frame%0d extra_par_load", d, fn), bad_par, 0);
                    end
                    fn++;
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    // Called aligned 1 time unit after a rising edge; returns the cycle stamp of the accepting edge
    task automatic send(input int d, input logic [7:0] b, input logic [10:0] f,
                        input bit hold, output int acc);
        int n;
        if (d == 0) begin
            bus_a.tx_data = b; bus_a.tx_valid = 1'b1; q_a.push_back(f);
        end else begin
            bus_b.tx_data = b; bus_b.tx_valid = 1'b1; q_b.push_back(f);
        end
        n = 0;
        while (!m_ready[d] && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 2000) begin
            vectors++;
            miscompares++;
            $display("FAIL dut%0d ready_timeout: tx_ready stayed 0 for %0d cycles, required 1", d, n);
        end
        @(posedge clk); #1;
        acc = cyc;
        if (!hold) begin
            if (d == 0) bus_a.tx_valid = 1'b0; else bus_b.tx_valid = 1'b0;
        end
    endtask

    initial begin
        #500000;
        miscompares++;
        $display("FAIL watchdog: time limit reached, required completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        int a1, a2;
        bus_a.tx_data = 8'h00; bus_a.tx_valid = 1'b0;
        bus_b.tx_data = 8'h00; bus_b.tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_bit($sformatf("dut%0d reset tx", d), m_tx[d], 1'b1);
            check_bit($sformatf("dut%0d reset ready", d), m_ready[d], 1'b1);
            check_bit($sformatf("dut%0d reset busy", d), m_busy[d], 1'b0);
            check_bit($sformatf("dut%0d reset done", d), m_done[d], 1'b0);
            check_bit($sformatf("dut%0d reset par_load", d), m_par[d], 1'b0);
        end
        @(posedge clk); #3 rst = 1'b0;
        @(posedge clk); #1;

        send(0, 8'h55, 11'b01010101001, 0, a1);

        send(0, 8'h07, 11'b01110000011, 0, a1);
        repeat (40) @(posedge clk);
        #1 bus_a.tx_data = 8'hAA; bus_a.tx_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus_a.tx_valid = 1'b0; bus_a.tx_data = 8'h00;

        send(0, 8'h00, 11'b00000000001, 0, a1);

        send(0, 8'h0F, 11'b01111000001, 0, a1);
        repeat (69) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;

        send(0, 8'h12, 11'b00100100001, 1, a1);
        bus_a.tx_data = 8'h34;
        repeat (50) @(posedge clk);
        #1 bus_a.tx_data = 8'hFF;
        repeat (50) @(posedge clk);
        #1 bus_a.tx_data = 8'h34;
        send(0, 8'h34, 11'b00010110011, 0, a2);
        check_int("b2b accept gap", a2 - a1, FRAME + 1);

        repeat (200) @(posedge clk); #1;
        send(1, 8'hA3, 11'b01100010111, 0, a1);

        repeat (250) @(posedge clk);
        check_int("dut0 leftover expected", q_a.size(), 0);
        check_int("dut1 leftover expected", q_b.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
